// File: rtl/mem_arb_nch_pkg.sv
// Shared types and widths for the N-channel main-memory request arbiter.
package mem_arb_nch_pkg;

    localparam int unsigned BLOCK_DATA_W          = 128;
    localparam int unsigned MAIN_MEM_BLOCK_ADDR_W = 26;
    localparam int unsigned ADDR_W                = 32;
    localparam int unsigned REQ_WIDTH_W           = 2;

    typedef logic [BLOCK_DATA_W-1:0]          block_data_t;
    typedef logic [MAIN_MEM_BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [ADDR_W-1:0]                addr_t;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

    typedef enum logic [1:0] {
        REQ_W_BYTE  = 2'd0,
        REQ_W_HALF  = 2'd1,
        REQ_W_WORD  = 2'd2,
        REQ_W_BLOCK = 2'd3
    } req_width_t;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_t;

    // Payload carried from a granted channel to main_mem.
    typedef struct packed {
        req_type_t            rtype;
        main_mem_block_addr_t block_addr;
        block_data_t          block_data;
        req_width_t           width;
        addr_t                addr;
    } mem_req_t;

    // Channel id width, never narrower than one bit.
    function automatic int unsigned ch_id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_nch_rr_arbiter.sv
// Combinational one-of-N arbiter: round-robin from a pointer or fixed
// lowest-index priority, returning a one-hot grant and its index.
module mem_arb_nch_rr_arbiter
    import mem_arb_nch_pkg::*;
#(
    parameter  int unsigned N_CH     = 2,
    parameter  int unsigned ARB_MODE = 0,
    localparam int unsigned CH_W     = ch_id_width(N_CH)
) (
    input  logic [N_CH-1:0] elig,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] gnt_c,
    output logic [CH_W-1:0] gnt_idx_c,
    output logic            gnt_vld_c
);

    // Scan from the lowest-priority candidate up so the highest-priority
    // eligible channel is the last one written.
    always_comb begin
        int unsigned idx;
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_vld_c = 1'b0;
        idx       = 0;
        if (ARB_MODE == 32'(ARB_FIXED)) begin
            for (int i = int'(N_CH) - 1; i >= 0; i--) begin
                if (elig[CH_W'(i)]) begin
                    gnt_c              = '0;
                    gnt_c[CH_W'(i)]    = 1'b1;
                    gnt_idx_c          = CH_W'(i);
                    gnt_vld_c          = 1'b1;
                end
            end
        end else begin
            for (int off = int'(N_CH) - 1; off >= 0; off--) begin
                idx = (32'(ptr) + 32'(off)) % N_CH;
                if (elig[CH_W'(idx)]) begin
                    gnt_c             = '0;
                    gnt_c[CH_W'(idx)] = 1'b1;
                    gnt_idx_c         = CH_W'(idx);
                    gnt_vld_c         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arb_nch.sv
// N-channel memory request arbiter: grants one requester per cycle, issues a
// registered tagged request to main_mem and routes read responses back.
module mem_arb_nch
    import mem_arb_nch_pkg::*;
#(
    parameter  int unsigned N_CH            = 2,
    parameter  int unsigned ARB_MODE        = 0,
    parameter  int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CH_W            = ch_id_width(N_CH),
    localparam int unsigned OS_W            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                               clk,
    input  logic                               rst_aL,
    input  logic [N_CH-1:0]                    ch_req_valid,
    input  logic [N_CH-1:0]                    ch_req_type,
    input  logic [N_CH*MAIN_MEM_BLOCK_ADDR_W-1:0] ch_req_block_addr,
    input  logic [N_CH*BLOCK_DATA_W-1:0]       ch_req_block_data,
    input  logic [N_CH*REQ_WIDTH_W-1:0]        ch_req_width,
    input  logic [N_CH*ADDR_W-1:0]             ch_req_addr,
    output logic [N_CH-1:0]                    ch_req_ready,
    output logic [N_CH-1:0]                    ch_resp_valid,
    output block_data_t                        ch_resp_block_data,
    output logic                               mem_req_valid,
    output logic [CH_W-1:0]                    mem_req_ch,
    output req_type_t                          mem_req_type,
    output main_mem_block_addr_t               mem_req_block_addr,
    output block_data_t                        mem_req_block_data,
    output req_width_t                         mem_req_width,
    output addr_t                              mem_req_addr,
    input  logic                               mem_resp_valid,
    input  logic [CH_W-1:0]                    mem_resp_ch,
    input  block_data_t                        mem_resp_block_data,
    output logic [OS_W-1:0]                    outstanding_cnt,
    output logic                               err_bad_resp
);

    logic [N_CH-1:0] elig_c;
    logic [N_CH-1:0] gnt_c;
    logic [CH_W-1:0] gnt_idx_c;
    logic            gnt_vld_c;
    logic [CH_W-1:0] rr_ptr;
    logic            cnt_full_c;
    logic            cnt_zero_c;
    logic            ch_ok_c;
    logic            rd_issue_c;
    logic            resp_dec_c;
    logic            resp_err_c;
    mem_req_t        sel_req_c;
    mem_req_t        mem_req_q;

    assign cnt_full_c = (outstanding_cnt >= OS_W'(MAX_OUTSTANDING));
    assign cnt_zero_c = (outstanding_cnt == '0);

    // Reads are held back once the outstanding budget is used; writes never are.
    always_comb begin
        elig_c = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            elig_c[i] = ch_req_valid[i] &
                        ((req_type_t'(ch_req_type[i]) == REQ_WRITE) | ~cnt_full_c);
        end
    end

    mem_arb_nch_rr_arbiter #(
        .N_CH     (N_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .elig      (elig_c),
        .ptr       (rr_ptr),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c),
        .gnt_vld_c (gnt_vld_c)
    );

    // Ready is masked during reset so no handshake is seen while held.
    assign ch_req_ready = rst_aL ? gnt_c : '0;

    // Select the granted channel's fields.
    always_comb begin
        sel_req_c = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (gnt_c[i]) begin
                sel_req_c.rtype      = req_type_t'(ch_req_type[i]);
                sel_req_c.block_addr = ch_req_block_addr[i*MAIN_MEM_BLOCK_ADDR_W +: MAIN_MEM_BLOCK_ADDR_W];
                sel_req_c.block_data = ch_req_block_data[i*BLOCK_DATA_W +: BLOCK_DATA_W];
                sel_req_c.width      = req_width_t'(ch_req_width[i*REQ_WIDTH_W +: REQ_WIDTH_W]);
                sel_req_c.addr       = ch_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign ch_ok_c    = (32'(mem_resp_ch) < N_CH);
    assign rd_issue_c = gnt_vld_c & (sel_req_c.rtype == REQ_READ);
    assign resp_dec_c = mem_resp_valid & ch_ok_c & ~cnt_zero_c;
    assign resp_err_c = mem_resp_valid & (~ch_ok_c | cnt_zero_c);

    // Request issue register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            mem_req_valid <= 1'b0;
            mem_req_ch    <= '0;
            mem_req_q     <= '0;
            rr_ptr        <= '0;
        end else begin
            mem_req_valid <= gnt_vld_c;
            if (gnt_vld_c) begin
                mem_req_ch <= gnt_idx_c;
                mem_req_q  <= sel_req_c;
                if (ARB_MODE == 32'(ARB_RR)) begin
                    rr_ptr <= (gnt_idx_c == CH_W'(N_CH - 1)) ? '0 : gnt_idx_c + CH_W'(1);
                end
            end
        end
    end

    assign mem_req_type       = mem_req_q.rtype;
    assign mem_req_block_addr = mem_req_q.block_addr;
    assign mem_req_block_data = mem_req_q.block_data;
    assign mem_req_width      = mem_req_q.width;
    assign mem_req_addr       = mem_req_q.addr;

    // Outstanding read count, response routing and sticky error.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            outstanding_cnt    <= '0;
            err_bad_resp       <= 1'b0;
            ch_resp_valid      <= '0;
            ch_resp_block_data <= '0;
        end else begin
            outstanding_cnt <= outstanding_cnt + OS_W'(rd_issue_c) - OS_W'(resp_dec_c);
            if (resp_err_c) begin
                err_bad_resp <= 1'b1;
            end
            if (mem_resp_valid & ch_ok_c) begin
                ch_resp_valid      <= N_CH'(1) << mem_resp_ch;
                ch_resp_block_data <= mem_resp_block_data;
            end else begin
                ch_resp_valid      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb_nch.sv
// Bench for mem_arb_nch: a round-robin instance and a fixed-priority instance
// driven with shared requests and checked against a behavioural model.
module tb_mem_arb_nch;
    import mem_arb_nch_pkg::*;

    localparam int unsigned NC = 3;
    localparam int unsigned BA = MAIN_MEM_BLOCK_ADDR_W;
    localparam int unsigned BD = BLOCK_DATA_W;
    localparam int unsigned AW = ADDR_W;
    localparam int unsigned WW = REQ_WIDTH_W;

    logic clk = 1'b0;
    logic rst_aL;
    always #5 clk = ~clk;

    logic [NC-1:0]    valid;
    logic [NC-1:0]    rtype;
    logic [NC*BA-1:0] baddr;
    logic [NC*BD-1:0] bdata;
    logic [NC*WW-1:0] width;
    logic [NC*AW-1:0] addr;
    logic             resp_v  [2];
    logic [1:0]       resp_ch [2];
    logic [BD-1:0]    resp_data;

    logic [NC-1:0]    o_ready  [2];
    logic [NC-1:0]    o_resp_v [2];
    logic [BD-1:0]    o_rdata  [2];
    logic             o_mv     [2];
    logic [1:0]       o_mch    [2];
    req_type_t        o_mtype  [2];
    logic [BA-1:0]    o_mbaddr [2];
    logic [BD-1:0]    o_mbdata [2];
    req_width_t       o_mwidth [2];
    logic [AW-1:0]    o_maddr  [2];
    logic             o_err    [2];
    logic [2:0]       cnt_rr;
    logic [1:0]       cnt_fx;
    logic [2:0]       o_cnt    [2];
    assign o_cnt[0] = cnt_rr;
    assign o_cnt[1] = {1'b0, cnt_fx};

    mem_arb_nch #(.N_CH(3), .ARB_MODE(0), .MAX_OUTSTANDING(4)) u_rr (
        .clk(clk), .rst_aL(rst_aL),
        .ch_req_valid(valid), .ch_req_type(rtype), .ch_req_block_addr(baddr),
        .ch_req_block_data(bdata), .ch_req_width(width), .ch_req_addr(addr),
        .ch_req_ready(o_ready[0]), .ch_resp_valid(o_resp_v[0]), .ch_resp_block_data(o_rdata[0]),
        .mem_req_valid(o_mv[0]), .mem_req_ch(o_mch[0]), .mem_req_type(o_mtype[0]),
        .mem_req_block_addr(o_mbaddr[0]), .mem_req_block_data(o_mbdata[0]),
        .mem_req_width(o_mwidth[0]), .mem_req_addr(o_maddr[0]),
        .mem_resp_valid(resp_v[0]), .mem_resp_ch(resp_ch[0]), .mem_resp_block_data(resp_data),
        .outstanding_cnt(cnt_rr), .err_bad_resp(o_err[0])
    );

    mem_arb_nch #(.N_CH(3), .ARB_MODE(1), .MAX_OUTSTANDING(2)) u_fx (
        .clk(clk), .rst_aL(rst_aL),
        .ch_req_valid(valid), .ch_req_type(rtype), .ch_req_block_addr(baddr),
        .ch_req_block_data(bdata), .ch_req_width(width), .ch_req_addr(addr),
        .ch_req_ready(o_ready[1]), .ch_resp_valid(o_resp_v[1]), .ch_resp_block_data(o_rdata[1]),
        .mem_req_valid(o_mv[1]), .mem_req_ch(o_mch[1]), .mem_req_type(o_mtype[1]),
        .mem_req_block_addr(o_mbaddr[1]), .mem_req_block_data(o_mbdata[1]),
        .mem_req_width(o_mwidth[1]), .mem_req_addr(o_maddr[1]),
        .mem_resp_valid(resp_v[1]), .mem_resp_ch(resp_ch[1]), .mem_resp_block_data(resp_data),
        .outstanding_cnt(cnt_fx), .err_bad_resp(o_err[1])
    );

    // Reference model state: instance 0 is round-robin/4, instance 1 fixed/2.
    int            m_ptr   [2];
    int            m_cnt   [2];
    bit            m_err   [2];
    bit            e_mv    [2];
    int            e_mch   [2];
    logic          e_mtype [2];
    logic [BA-1:0] e_baddr [2];
    logic [BD-1:0] e_bdata [2];
    logic [WW-1:0] e_width [2];
    logic [AW-1:0] e_addr  [2];
    logic [NC-1:0] e_rv    [2];
    logic [BD-1:0] e_rdata [2];
    logic [NC-1:0] obs_ready [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int max_os(input int n);
        return (n == 0) ? 4 : 2;
    endfunction

    // Which channel the arbitration rules say wins this cycle, or -1.
    function automatic int pick(input int n);
        bit [NC-1:0] el;
        for (int c = 0; c < int'(NC); c++)
            el[c] = valid[c] && (rtype[c] == 1'b1 || m_cnt[n] < max_os(n));
        if (n == 1) begin
            for (int c = 0; c < int'(NC); c++)
                if (el[c]) return c;
        end else begin
            for (int off = 0; off < int'(NC); off++)
                if (el[(m_ptr[n] + off) % int'(NC)]) return (m_ptr[n] + off) % int'(NC);
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_ptr[n] = 0; m_cnt[n] = 0; m_err[n] = 1'b0;
            e_mv[n] = 1'b0; e_rv[n] = '0;
        end
    endtask

    task automatic set_idle();
        valid = '0; rtype = '0;
        resp_v[0] = 1'b0; resp_v[1] = 1'b0;
        resp_ch[0] = '0; resp_ch[1] = '0;
    endtask

    task automatic rand_fields();
        for (int c = 0; c < int'(NC); c++) begin
            baddr[c*BA +: BA] = BA'($urandom);
            for (int w = 0; w < 4; w++) bdata[c*BD + w*32 +: 32] = $urandom;
            width[c*WW +: WW] = WW'($urandom);
            addr[c*AW +: AW]  = $urandom;
        end
        resp_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock: inputs already driven at the negedge; ends at the next negedge.
    task automatic cycle();
        int g [2];
        bit inc;
        bit dec;
        #1;
        for (int n = 0; n < 2; n++) begin
            g[n] = pick(n);
            obs_ready[n] = o_ready[n];
            check($sformatf("ready%0d", n), 128'(o_ready[n]),
                  128'((g[n] >= 0) ? (3'b001 << g[n]) : 3'b000));
        end
        for (int n = 0; n < 2; n++) begin
            inc = 1'b0; dec = 1'b0;
            e_mv[n] = (g[n] >= 0);
            e_rv[n] = '0;
            if (g[n] >= 0) begin
                e_mch[n]   = g[n];
                e_mtype[n] = rtype[g[n]];
                e_baddr[n] = baddr[g[n]*BA +: BA];
                e_bdata[n] = bdata[g[n]*BD +: BD];
                e_width[n] = width[g[n]*WW +: WW];
                e_addr[n]  = addr[g[n]*AW +: AW];
                inc = (rtype[g[n]] == 1'b0);
                if (n == 0) m_ptr[n] = (g[n] + 1) % int'(NC);
            end
            if (resp_v[n]) begin
                if (int'(resp_ch[n]) >= int'(NC)) begin
                    m_err[n] = 1'b1;
                end else begin
                    e_rv[n]    = 3'b001 << resp_ch[n];
                    e_rdata[n] = resp_data;
                    if (m_cnt[n] == 0) m_err[n] = 1'b1;
                    else dec = 1'b1;
                end
            end
            m_cnt[n] = m_cnt[n] + int'(inc) - int'(dec);
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            check($sformatf("cnt%0d", n),   128'(o_cnt[n]),    128'(m_cnt[n]));
            check($sformatf("err%0d", n),   128'(o_err[n]),    128'(m_err[n]));
            check($sformatf("mv%0d", n),    128'(o_mv[n]),     128'(e_mv[n]));
            check($sformatf("rvld%0d", n),  128'(o_resp_v[n]), 128'(e_rv[n]));
            if (e_mv[n]) begin
                check($sformatf("mch%0d", n),    128'(o_mch[n]),    128'(e_mch[n]));
                check($sformatf("mtype%0d", n),  128'(o_mtype[n]),  128'(e_mtype[n]));
                check($sformatf("mbaddr%0d", n), 128'(o_mbaddr[n]), 128'(e_baddr[n]));
                check($sformatf("mbdata%0d", n), 128'(o_mbdata[n]), 128'(e_bdata[n]));
                check($sformatf("mwidth%0d", n), 128'(o_mwidth[n]), 128'(e_width[n]));
                check($sformatf("maddr%0d", n),  128'(o_maddr[n]),  128'(e_addr[n]));
            end
            if (e_rv[n] != '0)
                check($sformatf("rdata%0d", n), 128'(o_rdata[n]), 128'(e_rdata[n]));
        end
        @(negedge clk);
    endtask

    task automatic drain();
        set_idle();
        for (int k = 0; k < 12 && (m_cnt[0] > 0 || m_cnt[1] > 0); k++) begin
            resp_v[0] = (m_cnt[0] > 0);
            resp_v[1] = (m_cnt[1] > 0);
            cycle();
        end
        set_idle();
        check("drain_rr", 128'(o_cnt[0]), 128'(0));
        check("drain_fx", 128'(o_cnt[1]), 128'(0));
    endtask

    task automatic do_reset();
        set_idle();
        rst_aL = 1'b0;
        model_reset();
        @(negedge clk);
        rst_aL = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int n = 0; n < 2; n++) begin
            check({tag, "_ready"}, 128'(o_ready[n]),  128'(0));
            check({tag, "_mv"},    128'(o_mv[n]),     128'(0));
            check({tag, "_mch"},   128'(o_mch[n]),    128'(0));
            check({tag, "_rv"},    128'(o_resp_v[n]), 128'(0));
            check({tag, "_rdata"}, 128'(o_rdata[n]),  128'(0));
            check({tag, "_cnt"},   128'(o_cnt[n]),    128'(0));
            check({tag, "_err"},   128'(o_err[n]),    128'(0));
        end
    endtask

    initial begin
        rst_aL = 1'b0;
        set_idle();
        rand_fields();
        model_reset();
        valid = 3'b111;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_aL = 1'b1;
        set_idle();

        // Random traffic; responses only for reads actually in flight.
        repeat (400) begin
            rand_fields();
            valid = NC'($urandom);
            rtype = NC'($urandom);
            for (int n = 0; n < 2; n++) begin
                resp_v[n]  = (m_cnt[n] > 0) && ($urandom_range(0, 1) == 1);
                resp_ch[n] = 2'($urandom_range(0, 2));
            end
            cycle();
        end

        // Round-robin rotation with a response returned every cycle.
        do_reset();
        valid = 3'b111; rtype = 3'b000;
        for (int i = 0; i < 6; i++) begin
            rand_fields();
            resp_v[0] = (m_cnt[0] > 0);
            resp_v[1] = (m_cnt[1] > 0);
            cycle();
            check("rr_seq", 128'(obs_ready[0]), 128'(3'b001 << (i % 3)));
            check("rr_mch", 128'(o_mch[0]), 128'(i % 3));
        end

        // Fixed priority starves channel 2 while channel 0 requests.
        drain();
        valid = 3'b101; rtype = 3'b101;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("fx_prio", 128'(obs_ready[1]), 128'(3'b001));
        end
        valid = 3'b100;
        cycle();
        check("fx_ch2", 128'(obs_ready[1]), 128'(3'b100));

        // Outstanding limit of 2 on the fixed instance.
        drain();
        valid = 3'b001; rtype = 3'b000; cycle();
        check("lim_r0", 128'(obs_ready[1]), 128'(3'b001));
        valid = 3'b010; cycle();
        check("lim_r1", 128'(obs_ready[1]), 128'(3'b010));
        valid = 3'b100; cycle();
        check("lim_stall", 128'(obs_ready[1]), 128'(3'b000));
        check("lim_cnt2", 128'(o_cnt[1]), 128'(2));
        valid = 3'b110; rtype = 3'b010; cycle();
        check("lim_wr", 128'(obs_ready[1]), 128'(3'b010));
        valid = 3'b100; rtype = 3'b000; resp_v[1] = 1'b1; resp_ch[1] = 2'd0; cycle();
        check("lim_stall2", 128'(obs_ready[1]), 128'(3'b000));
        check("lim_cnt1", 128'(o_cnt[1]), 128'(1));
        resp_v[1] = 1'b0; cycle();
        check("lim_go", 128'(obs_ready[1]), 128'(3'b100));

        // Same-cycle read grant and response keeps the count.
        drain();
        valid = 3'b001; rtype = 3'b000; cycle();
        check("same_pre", 128'(o_cnt[0]), 128'(1));
        valid = 3'b010;
        resp_v[0] = 1'b1; resp_ch[0] = 2'd0;
        resp_data = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        cycle();
        check("same_cnt", 128'(o_cnt[0]), 128'(1));
        check("same_rv", 128'(o_resp_v[0]), 128'(3'b001));
        check("same_data", 128'(o_rdata[0]), 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);

        // Response tagged with a nonexistent channel.
        drain();
        resp_v[0] = 1'b1; resp_ch[0] = 2'd3; cycle();
        check("badch_rv", 128'(o_resp_v[0]), 128'(0));
        check("badch_err", 128'(o_err[0]), 128'(1));
        set_idle(); cycle();
        check("badch_sticky", 128'(o_err[0]), 128'(1));

        // Response with nothing outstanding.
        check("uf_pre", 128'(o_err[1]), 128'(0));
        resp_v[1] = 1'b1; resp_ch[1] = 2'd0; cycle();
        check("uf_err", 128'(o_err[1]), 128'(1));
        check("uf_cnt", 128'(o_cnt[1]), 128'(0));

        // Asynchronous reset in the middle of a read burst.
        drain();
        valid = 3'b111; rtype = 3'b000;
        repeat (3) cycle();
        check("burst_cnt", 128'(o_cnt[0]), 128'(3));
        @(posedge clk);
        #2;
        rst_aL = 1'b0;
        #1;
        check_all_zero("async");
        model_reset();
        @(negedge clk);
        rst_aL = 1'b1;
        cycle();
        check("rst_first", 128'(obs_ready[0]), 128'(3'b001));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arb_nch.md
Name: mem_arb_nch

Overview:
N-channel memory request arbiter. It generalises the fixed two-requester (icache/dcache) memory controller to N_CH requesters, with selectable arbitration mode and a bounded count of outstanding reads. It sits between the cache/requester set and main_mem. Toward the requesters it presents latency-insensitive valid/ready requests and latency-sensitive responses. Toward main_mem it presents one registered request stream tagged by channel id.

Parameters:
N_CH, 2, number of requester channels (2..8)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
MAX_OUTSTANDING, 4, maximum reads issued to main_mem and not yet responded (1..15)
localparam CH_W, max(1,$clog2(N_CH)), channel id width
localparam OS_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
clk  in  1  clock
rst_aL  in  1  asynchronous active-low reset
ch_req_valid  in  N_CH  per-channel request valid
ch_req_type  in  N_CH  per-channel req_type_t (0 read, 1 write)
ch_req_block_addr  in  N_CH*`MAIN_MEM_BLOCK_ADDR_WIDTH  per-channel block address
ch_req_block_data  in  N_CH*`BLOCK_DATA_WIDTH  per-channel write data
ch_req_width  in  N_CH*2  per-channel req_width_t
ch_req_addr  in  N_CH*`ADDR_WIDTH  per-channel byte address (stores)
ch_req_ready  out  N_CH  one-hot grant; a handshake occurs when valid&ready
ch_resp_valid  out  N_CH  one-hot read response valid
ch_resp_block_data  out  `BLOCK_DATA_WIDTH  response data, broadcast to all channels
mem_req_valid  out  1  request to main_mem
mem_req_ch  out  CH_W  originating channel id
mem_req_type, mem_req_block_addr, mem_req_block_data, mem_req_width, mem_req_addr  out  as per channel  registered copy of the granted request
mem_resp_valid  in  1  main_mem read response
mem_resp_ch  in  CH_W  channel id echoed by main_mem
mem_resp_block_data  in  `BLOCK_DATA_WIDTH  read data
outstanding_cnt  out  OS_W  reads in flight
err_bad_resp  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock clk. Reset rst_aL is asynchronous and active-low.
- Reset values: all valids and readies 0, data outputs 0, outstanding_cnt 0, round-robin pointer 0, err_bad_resp 0.
- Eligibility: channel i is eligible when ch_req_valid[i] is high, and, if the request is a read, outstanding_cnt < MAX_OUTSTANDING. Writes are always eligible.
- Grant: at most one grant per cycle. ch_req_ready is combinational from the eligibility vector, the mode and the pointer. ch_req_ready[i] is never high unless ch_req_valid[i] is high.
- RR mode: search starts at the pointer and wraps modulo N_CH. After a grant to channel k, the pointer becomes (k+1) mod N_CH. With no grant, the pointer holds.
- Fixed mode: the lowest eligible index wins. The pointer is unused.
- Issue: a grant in cycle T produces mem_req_valid=1 in T+1 carrying the captured fields and mem_req_ch=k. mem_req_valid is a 1-cycle pulse. Back-to-back grants give back-to-back pulses. main_mem never backpressures.
- Counter: increments on a granted read. Decrements on accepted mem_resp_valid with a valid channel id. If both happen in one cycle, the counter is unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
- Underflow guard: a response arriving with the counter at 0 sets err_bad_resp and does not decrement.
- Writes produce no response and do not touch the counter.
- Response: mem_resp_valid in cycle R produces ch_resp_valid[mem_resp_ch]=1 and the data in R+1, for one cycle. Responses are latency-sensitive; there is no ready.
- Bad channel: mem_resp_ch >= N_CH drops the response and sets err_bad_resp. The flag clears only on reset.
- Reset mid-operation: in-flight responses are lost. After reset deassertion, everything restarts from the reset values.

Decomposition:
- Shared header misc/global_defs.svh gains typedef chan_id_t (logic [CH_W-1:0]) and arb_mode_t (ARB_RR=0, ARB_FIXED=1).
- It reuses the existing req_type_t, req_width_t, block_data_t, main_mem_block_addr_t and addr_t.
- Sub-module rr_arbiter(N_CH, ARB_MODE): takes the eligibility vector and pointer, and returns a one-hot grant plus an encoded index. It is purely combinational. The pointer register stays in mem_arb_nch.

Test Plan:
- N_CH=3, RR: all three channels assert valid reads continuously at MAX_OUTSTANDING=4, with mem_resp returned every cycle -> grants 0,1,2,0,1,2. Each mem_req_valid is 1 cycle after its grant, with mem_req_ch matching.
- ARB_MODE=1: channels 0 and 2 are both valid for 3 cycles -> channel 0 is granted all 3 cycles and channel 2 is starved until channel 0 drops.
- MAX_OUTSTANDING=2: issue 3 reads with no responses -> the third read stays not-ready and outstanding_cnt=2. A write on channel 1 is still granted. A response returns -> cnt=1 and the third read is granted the next cycle.
- Same-cycle grant and response: cnt=1, a new read is granted while mem_resp_valid with ch=0 arrives -> cnt stays 1 and ch_resp_valid=3'b001 one cycle later with data 0xDEADBEEF..., matching the input.
- mem_resp_ch=3 with N_CH=3 -> no ch_resp_valid, err_bad_resp=1 and it stays 1. Separately, a response with cnt=0 -> err_bad_resp=1 and cnt stays 0.
- Assert rst_aL low mid-burst with cnt=3 -> all outputs are 0 immediately (asynchronously). After release, the first grant goes to channel 0.
